// File: rtl/load_store_unit.sv
// load_store_unit
//   Sits between the EX/MEM stage and a word-wide data memory. Each accepted
//   request runs as a short multi-cycle operation. The unit holds the pipeline
//   with stall until the operation is done and signals completion with a
//   single resp_valid pulse.
//     store / no-op : accept N, STORE N+1 (dm_wr, response), IDLE N+2
//     load          : accept N, LOAD_REQ N+1 (dm_re), LOAD_DATA N+2 (dm_rd
//                     captured), RESP N+3 (response), IDLE N+4
//
//   Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned halfword
//   and word accesses. A trapped access makes no memory access and responds in
//   N+1 with misalign=1 and resp_data=0. When the macro is undefined, the low
//   offset bits are ignored and misalign is tied to 0.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   MemRead, MemWrite    load / store strobes (MemRead wins if both are set)
//   Funct3, addr, wdata  access type, byte address, store data
//   resp_valid           one-cycle completion pulse
//   resp_data            extended load result (0 for stores), held between ops
//   misalign             misaligned-access flag, qualified by resp_valid
//   stall                high whenever the unit is not in IDLE
//   dm_addr/dm_wd/dm_wr  word address, lane-replicated data, byte enables
//   dm_re, dm_rd         read strobe; read data valid the cycle after dm_re
module load_store_unit #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_data,
    output logic                  misalign,
    output logic                  stall,
    output logic [DM_ADDRESS-1:0] dm_addr,
    output logic [DATA_W-1:0]     dm_wd,
    output logic [3:0]            dm_wr,
    output logic                  dm_re,
    input  logic [DATA_W-1:0]     dm_rd
);

    typedef enum logic [2:0] {
        IDLE,
        STORE,
        LOAD_REQ,
        LOAD_DATA,
        RESP
    } state_t;

    state_t state, state_nx;

    logic [DM_ADDRESS-1:0] addr_p1;
    logic [DATA_W-1:0]     wdata_p1;
    logic [2:0]            f3_p1;
    logic                  wr_p1;
    logic [DATA_W-1:0]     resp_data_p1;
    logic                  accept;
    logic                  mis_now;
    logic                  mis_p1;

    // Byte enables for a store of the given type at the given byte offset.
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000:  return 4'b0001 << off;
            3'b001:  return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate store data across all lanes so that the enables select the lane.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return {4{d[7:0]}};
            3'b001:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Pick the lane addressed by the offset, then sign- or zero-extend it.
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rd);
        logic [31:0]        shifted;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        shifted = rd >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  return 32'(b);
            3'b001:  return 32'(h);
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return rd;
        endcase
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    // Halfwords need addr[0]=0 and words need addr[1:0]=0. A request with
    // neither strobe set makes no access, so it never traps.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b001, 3'b101: return off[0];
            3'b010:         return off != 2'b00;
            default:        return 1'b0;
        endcase
    endfunction

    assign mis_now = (MemRead || MemWrite) && is_misaligned(Funct3, addr[1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       mis_p1 <= 1'b0;
        else if (accept) mis_p1 <= mis_now;
    end
`else
    assign mis_now = 1'b0;
    assign mis_p1  = 1'b0;
`endif

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (mis_now)      state_nx = RESP;
                    else if (MemRead) state_nx = LOAD_REQ;
                    else              state_nx = STORE;
                end
            end
            STORE:     state_nx = IDLE;
            LOAD_REQ:  state_nx = LOAD_DATA;
            LOAD_DATA: state_nx = RESP;
            RESP:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Request capture: accepted in N, visible from N+1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_p1      <= '0;
            wdata_p1     <= '0;
            f3_p1        <= '0;
            wr_p1        <= 1'b0;
            resp_data_p1 <= '0;
        end else if (accept) begin
            addr_p1  <= addr;
            wdata_p1 <= wdata;
            f3_p1    <= Funct3;
            // MemRead takes priority, so a combined request never writes.
            wr_p1    <= MemWrite && !MemRead && !mis_now;
            // Stores and traps respond with zero in the very next cycle.
            if (!MemRead || mis_now) resp_data_p1 <= '0;
        end else if (state == LOAD_DATA) begin
            resp_data_p1 <= load_ext(f3_p1, addr_p1[1:0], dm_rd);
        end
    end

    assign stall      = (state != IDLE);
    assign resp_valid = (state == STORE) || (state == RESP);
    assign misalign   = (state == RESP) && mis_p1;
    assign resp_data  = resp_data_p1;
    assign dm_addr    = {addr_p1[DM_ADDRESS-1:2], 2'b00};
    assign dm_wd      = store_data(f3_p1, wdata_p1);
    assign dm_wr      = (state == STORE && wr_p1) ? store_be(f3_p1, addr_p1[1:0]) : 4'b0000;
    assign dm_re      = (state == LOAD_REQ);

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        misalign;
    logic        stall;
    logic [8:0]  dm_addr;
    logic [31:0] dm_wd;
    logic [3:0]  dm_wr;
    logic        dm_re;
    logic [31:0] dm_rd;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [31:0] JUNK = 32'h5A5A_5A5A;

    load_store_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3), .addr(addr),
        .wdata(wdata), .resp_valid(resp_valid), .resp_data(resp_data),
        .misalign(misalign), .stall(stall), .dm_addr(dm_addr), .dm_wd(dm_wd),
        .dm_wr(dm_wr), .dm_re(dm_re), .dm_rd(dm_rd)
    );

    always #5 clk = ~clk;

    // kind: 0 = store / no-op, 1 = load, 2 = misaligned trap
    typedef struct {
        string       name;
        logic        mr;
        logic        mw;
        logic [2:0]  f3;
        logic [8:0]  a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          kind;
        logic [8:0]  e_addr;
        logic [3:0]  e_wr;
        logic [31:0] e_wd;
        logic [31:0] e_resp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic issue(input vec_t v);
        @(negedge clk);
        req_valid = 1'b1;
        MemRead   = v.mr;
        MemWrite  = v.mw;
        Funct3    = v.f3;
        addr      = v.a;
        wdata     = v.wd;
        dm_rd     = JUNK;
        chkb({v.name, " req_ready idle"}, req_ready, 1'b1);
    endtask

    // req_valid stays high while busy; the unit must not take it until IDLE.
    task automatic run_vec(input vec_t v);
        issue(v);
        @(negedge clk);  // N+1
        if (v.kind == 0) begin
            chk ({v.name, " dm_addr"},    32'(dm_addr), 32'(v.e_addr));
            chk ({v.name, " dm_wr"},      32'(dm_wr), 32'(v.e_wr));
            if (v.e_wr != 4'b0000) chk({v.name, " dm_wd"}, dm_wd, v.e_wd);
            chkb({v.name, " resp_valid"}, resp_valid, 1'b1);
            chk ({v.name, " resp_data"},  resp_data, 32'h0);
            chkb({v.name, " misalign"},   misalign, 1'b0);
            chkb({v.name, " dm_re"},      dm_re, 1'b0);
            chkb({v.name, " stall"},      stall, 1'b1);
            chkb({v.name, " req_ready busy"}, req_ready, 1'b0);
            req_valid = 1'b0;
            @(negedge clk);  // N+2
            chk ({v.name, " dm_wr after"},      32'(dm_wr), 32'h0);
            chkb({v.name, " resp_valid after"}, resp_valid, 1'b0);
            chkb({v.name, " stall after"},      stall, 1'b0);
            chkb({v.name, " req_ready after"},  req_ready, 1'b1);
        end else if (v.kind == 1) begin
            chkb({v.name, " dm_re"},      dm_re, 1'b1);
            chk ({v.name, " dm_addr"},    32'(dm_addr), 32'(v.e_addr));
            chk ({v.name, " dm_wr n1"},   32'(dm_wr), 32'h0);
            chkb({v.name, " resp_valid n1"}, resp_valid, 1'b0);
            chkb({v.name, " req_ready n1"},  req_ready, 1'b0);
            @(negedge clk);  // N+2: memory data presented only in this cycle
            chkb({v.name, " dm_re n2"},   dm_re, 1'b0);
            chk ({v.name, " dm_wr n2"},   32'(dm_wr), 32'h0);
            chkb({v.name, " stall n2"},   stall, 1'b1);
            chkb({v.name, " req_ready n2"}, req_ready, 1'b0);
            dm_rd = v.rd;
            @(negedge clk);  // N+3
            dm_rd = JUNK;
            chkb({v.name, " resp_valid"}, resp_valid, 1'b1);
            chk ({v.name, " resp_data"},  resp_data, v.e_resp);
            chkb({v.name, " misalign"},   misalign, 1'b0);
            chk ({v.name, " dm_wr n3"},   32'(dm_wr), 32'h0);
            chkb({v.name, " req_ready n3"}, req_ready, 1'b0);
            req_valid = 1'b0;
            @(negedge clk);  // N+4
            chkb({v.name, " resp_valid after"}, resp_valid, 1'b0);
            chkb({v.name, " req_ready after"},  req_ready, 1'b1);
            chk ({v.name, " resp_data held"},   resp_data, v.e_resp);
        end else begin
            chkb({v.name, " trap resp_valid"}, resp_valid, 1'b1);
            chkb({v.name, " trap misalign"},   misalign, 1'b1);
            chk ({v.name, " trap resp_data"},  resp_data, 32'h0);
            chk ({v.name, " trap dm_wr"},      32'(dm_wr), 32'h0);
            chkb({v.name, " trap dm_re"},      dm_re, 1'b0);
            req_valid = 1'b0;
            @(negedge clk);  // N+2
            chkb({v.name, " trap resp_valid after"}, resp_valid, 1'b0);
            chkb({v.name, " trap misalign after"},   misalign, 1'b0);
            chk ({v.name, " trap dm_wr after"},      32'(dm_wr), 32'h0);
            chkb({v.name, " trap req_ready after"},  req_ready, 1'b1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                name     mr    mw    f3      addr    wdata          dm_rd          kind e_addr  e_wr     e_wd           e_resp
        vecs[0]  = '{"SB",    1'b0, 1'b1, 3'b000, 9'h006, 32'h0000_00AB, 32'h0,         0, 9'h004, 4'b0100, 32'hABAB_ABAB, 32'h0};
        vecs[1]  = '{"SH",    1'b0, 1'b1, 3'b001, 9'h002, 32'h1234_BEEF, 32'h0,         0, 9'h000, 4'b1100, 32'hBEEF_BEEF, 32'h0};
        vecs[2]  = '{"SW",    1'b0, 1'b1, 3'b010, 9'h010, 32'hDEAD_BEEF, 32'h0,         0, 9'h010, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vecs[3]  = '{"NOP",   1'b0, 1'b0, 3'b010, 9'h008, 32'h7777_7777, 32'h0,         0, 9'h008, 4'b0000, 32'h7777_7777, 32'h0};
        vecs[4]  = '{"LB",    1'b1, 1'b0, 3'b000, 9'h00D, 32'h0,         32'h1234_F600, 1, 9'h00C, 4'b0000, 32'h0,         32'hFFFF_FFF6};
        vecs[5]  = '{"LBU",   1'b1, 1'b0, 3'b100, 9'h00D, 32'h0,         32'h1234_F600, 1, 9'h00C, 4'b0000, 32'h0,         32'h0000_00F6};
        vecs[6]  = '{"LHU",   1'b1, 1'b0, 3'b101, 9'h002, 32'h0,         32'h8001_ABCD, 1, 9'h000, 4'b0000, 32'h0,         32'h0000_8001};
        vecs[7]  = '{"LH",    1'b1, 1'b0, 3'b001, 9'h002, 32'h0,         32'h8001_ABCD, 1, 9'h000, 4'b0000, 32'h0,         32'hFFFF_8001};
        vecs[8]  = '{"LW",    1'b1, 1'b0, 3'b010, 9'h020, 32'h0,         32'hCAFE_F00D, 1, 9'h020, 4'b0000, 32'h0,         32'hCAFE_F00D};
        vecs[9]  = '{"RDWR",  1'b1, 1'b1, 3'b010, 9'h010, 32'hFFFF_FFFF, 32'h0102_0304, 1, 9'h010, 4'b0000, 32'h0,         32'h0102_0304};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[10] = '{"SWmis", 1'b0, 1'b1, 3'b010, 9'h003, 32'h1122_3344, 32'h0,         2, 9'h000, 4'b0000, 32'h0,         32'h0};
        vecs[11] = '{"LHmis", 1'b1, 1'b0, 3'b001, 9'h001, 32'h0,         32'h0000_8765, 2, 9'h000, 4'b0000, 32'h0,         32'h0};
`else
        vecs[10] = '{"SWmis", 1'b0, 1'b1, 3'b010, 9'h003, 32'h1122_3344, 32'h0,         0, 9'h000, 4'b1111, 32'h1122_3344, 32'h0};
        vecs[11] = '{"LHmis", 1'b1, 1'b0, 3'b001, 9'h001, 32'h0,         32'h0000_8765, 1, 9'h000, 4'b0000, 32'h0,         32'hFFFF_8765};
`endif

        reset = 1'b1; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Funct3 = 3'b000; addr = '0; wdata = '0; dm_rd = JUNK;

        @(negedge clk);
        chkb("rst req_ready",  req_ready, 1'b0);
        chkb("rst stall",      stall, 1'b0);
        chkb("rst resp_valid", resp_valid, 1'b0);
        chkb("rst misalign",   misalign, 1'b0);
        chk ("rst dm_wr",      32'(dm_wr), 32'h0);
        chkb("rst dm_re",      dm_re, 1'b0);
        chk ("rst resp_data",  resp_data, 32'h0);
        chk ("rst dm_addr",    32'(dm_addr), 32'h0);
        chk ("rst dm_wd",      dm_wd, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Reset during LOAD_REQ abandons the load.
        issue(vecs[8]);
        @(negedge clk);
        chkb("midrst dm_re before", dm_re, 1'b1);
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        chkb("midrst dm_re",      dm_re, 1'b0);
        chkb("midrst stall",      stall, 1'b0);
        chkb("midrst req_ready",  req_ready, 1'b0);
        chkb("midrst resp_valid", resp_valid, 1'b0);
        chk ("midrst dm_addr",    32'(dm_addr), 32'h0);
        @(negedge clk);
        dm_rd = vecs[8].rd;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chkb("midrst no resp",  resp_valid, 1'b0);
            chkb("midrst no stall", stall, 1'b0);
            chk ("midrst no write", 32'(dm_wr), 32'h0);
        end
        dm_rd = JUNK;
        run_vec(vecs[8]);
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DM_ADDRESS, default 9: data-memory byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width; only 32 is supported.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1: the EX/MEM stage presents a memory operation.
REQ-006 SHALL have port req_ready, output, 1: the unit accepts a request this cycle.
REQ-007 SHALL have ports MemRead, input, 1, and MemWrite, input, 1: control-unit load and store strobes.
REQ-008 SHALL have port Funct3, input, 3: instruction bits 14:12.
REQ-009 SHALL have port addr, input, DM_ADDRESS: byte address taken from the ALU result.
REQ-010 SHALL have port wdata, input, DATA_W: store data from rs2.
REQ-011 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port resp_data, output, DATA_W: extended load result.
REQ-013 SHALL have port misalign, output, 1: misaligned-access flag, qualified by resp_valid.
REQ-014 SHALL have port stall, output, 1: holds the pipeline while an operation is in flight.
REQ-015 SHALL have port dm_addr, output, DM_ADDRESS: word-aligned address to data memory.
REQ-016 SHALL have port dm_wd, output, DATA_W: lane-replicated write data.
REQ-017 SHALL have port dm_wr, output, 4: byte write enables.
REQ-018 SHALL have port dm_re, output, 1: read strobe to data memory.
REQ-019 SHALL have port dm_rd, input, DATA_W: memory read data, valid the cycle after dm_re.

Function
REQ-020 SHALL implement FSM states IDLE, STORE, LOAD_REQ, LOAD_DATA, RESP.
- req_ready=1 only in IDLE with reset low.
- stall=1 in every state except IDLE.
REQ-021 SHALL accept a request when req_valid&&req_ready, registering addr, wdata, Funct3 and the strobes.
REQ-022 SHALL give MemRead priority when MemRead&&MemWrite: treated as a load, no write occurs.
REQ-023 SHALL run stores (and requests with neither strobe) as follows, with accept in cycle N:
- STORE in N+1: dm_wr driven for exactly that cycle; resp_valid=1, resp_data=0.
- IDLE in N+2.
- dm_wr=0 when neither strobe was set.
REQ-024 SHALL run loads as follows, with accept in cycle N:
- LOAD_REQ in N+1: dm_re=1.
- LOAD_DATA in N+2: dm_rd captured and extended.
- RESP in N+3: resp_valid=1 with resp_data.
- IDLE in N+4.
REQ-025 SHALL drive dm_addr={addr[DM_ADDRESS-1:2],2'b00} from the registered address.
REQ-026 SHALL set byte enables and write data by store type:
- SB: dm_wr=4'b0001<<addr[1:0], dm_wd={4{wdata[7:0]}}.
- SH: dm_wr=4'b0011<<{addr[1],1'b0}, dm_wd={2{wdata[15:0]}}.
- SW and any other Funct3: dm_wr=4'b1111, dm_wd=wdata.
REQ-027 SHALL form load results from the byte or halfword lane selected by addr[1:0] or addr[1]:
- LB, LH: sign-extend.
- LBU (100), LHU (101): zero-extend.
- LW and any other Funct3: full word.
REQ-028 SHALL drive dm_wr=0 and dm_re=0 in every state other than STORE and LOAD_REQ.
REQ-029 SHALL hold resp_valid and misalign at 0 outside the response cycle; resp_data SHALL hold its last value.

Reset
REQ-030 SHALL, while reset is high, immediately force:
- state to IDLE;
- req_ready, stall, resp_valid, misalign, dm_wr and dm_re to 0;
- resp_data, dm_addr and dm_wd to 0.
REQ-031 SHALL abandon an in-flight operation when reset is asserted mid-operation: no write completes, and no response is produced after reset is released.

Configuration
REQ-032 SHALL use macro LSU_MISALIGN_TRAP_EN to select misaligned-access handling.
- Defined: a misaligned LH/LHU/SH (addr[0]=1) or LW/SW (addr[1:0]!=0) accepted in cycle N SHALL produce no memory access; resp_valid=1, misalign=1 and resp_data=0 in N+1; IDLE in N+2.
- Undefined: misalign SHALL be tied 0; offset bits below the access size SHALL be ignored and the access SHALL proceed normally.

Verification
REQ-033 Store SB: wdata=0x000000AB, addr=0x006 -> dm_addr=0x004, dm_wr=0100, dm_wd=0xABABABAB, in N+1 only.
REQ-034 Load LB: addr=0x00D, dm_rd=0x1234F600 -> resp_data=0xFFFFFFF6 in N+3; LBU with the same inputs -> 0x000000F6.
REQ-035 Load LHU: addr=0x002, dm_rd=0x8001ABCD -> resp_data=0x00008001; LH with the same inputs -> 0xFFFF8001.
REQ-036 MemRead=MemWrite=1, Funct3=010, addr=0x010 -> dm_re pulses and dm_wr stays 0000 throughout; back-to-back req_valid is held off by req_ready=0 until IDLE.
REQ-037 SW at addr=0x003:
- With LSU_MISALIGN_TRAP_EN: misalign=1 and resp_valid=1 in N+1, dm_wr=0000 throughout.
- Without it: dm_addr=0x000, dm_wr=1111.
REQ-038 Reset asserted in LOAD_REQ -> dm_re=0, stall=0 at once; no resp_valid after release; the next request completes normally.
